gpio_log_ctrl: RTL

GPIO_LOG_CTRL -- requirements
Module: gpio_log_ctrl

---
 rtl/gpio_log_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/gpio_log_ctrl.sv
// gpio_log_ctrl: processor GPO command decoder plus NB_CH-channel sample logger with GPI readback.
// Optional: define LOG_TRIGGER_EN to add the i_trigger input and the ARM (wait-for-trigger) state.
module gpio_log_ctrl #(
    parameter int unsigned NB_CH     = 2,
    parameter int unsigned NB_SAMPLE = 16,
    parameter int unsigned RAM_DEPTH = 32768
) (
    input  logic                       clockdsp,
    input  logic                       i_reset,
    input  logic [31:0]                i_gpo,
    input  logic [NB_CH*NB_SAMPLE-1:0] i_samples,
    input  logic                       i_valid,
`ifdef LOG_TRIGGER_EN
    input  logic                       i_trigger,
`endif
    output logic [31:0]                o_gpi,
    output logic                       o_soft_reset,
    output logic                       o_enable_tx,
    output logic                       o_enable_rx,
    output logic                       o_log_busy,
    output logic                       o_log_full
);

    localparam int unsigned ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

`ifdef LOG_TRIGGER_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LOG, ST_ARM} state_t;
`else
    typedef enum logic {ST_IDLE, ST_LOG} state_t;
`endif

    state_t              state, state_n;
    logic [31:0]         gpo_q, gpo_qq;
    logic                primed;
    logic [ADDR_W-1:0]   wr_ptr, wr_ptr_n;
    logic [ADDR_W-1:0]   rd_ptr, rd_addr;
    logic [2:0]          rd_ch, rd_ch_q, rd_ch_qq;
    logic                full, full_n;
    logic                wr_en;
    logic                start_bit, read_bit;
    logic                rd_issue, rd_valid;
    logic [23:0]         gpi_data;
    logic [7:0]          cmd;
    logic                exec, start, stop;
    logic [NB_CH*NB_SAMPLE-1:0] rd_all;
    logic [NB_SAMPLE-1:0]       rd_sel;

    assign cmd   = gpo_q[31:24];
    assign exec  = (gpo_q != gpo_qq) && gpo_q[23];
    assign start = exec && (cmd == 8'h03) && gpo_q[0] && !start_bit;
    assign stop  = exec && (cmd == 8'h03) && !gpo_q[0];

    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        full_n   = full;
        wr_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    wr_ptr_n = '0;
                    full_n   = 1'b0;
`ifdef LOG_TRIGGER_EN
                    state_n  = gpo_q[1] ? ST_ARM : ST_LOG;
`else
                    state_n  = ST_LOG;
`endif
                end
            end
            ST_LOG: begin
                wr_en = i_valid;
            end
`ifdef LOG_TRIGGER_EN
            ST_ARM: begin
                wr_en = i_valid && i_trigger;
                if (wr_en) state_n = ST_LOG;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
        if (wr_en) begin
            wr_ptr_n = wr_ptr + ADDR_W'(1);
            if (wr_ptr == LAST_ADDR) begin
                full_n  = 1'b1;
                state_n = ST_IDLE;
            end
        end
        if (stop && (state != ST_IDLE)) state_n = ST_IDLE;
    end

    always_ff @(posedge clockdsp or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            gpo_q        <= '0;
            gpo_qq       <= '0;
            primed       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_addr      <= '0;
            rd_ch        <= '0;
            rd_ch_q      <= '0;
            rd_ch_qq     <= '0;
            full         <= 1'b0;
            start_bit    <= 1'b0;
            read_bit     <= 1'b0;
            rd_issue     <= 1'b0;
            rd_valid     <= 1'b0;
            gpi_data     <= '0;
            o_soft_reset <= 1'b1;
            o_enable_tx  <= 1'b0;
            o_enable_rx  <= 1'b0;
        end else begin
            // First capture after reset seeds both stages, so a word held across reset is not a change.
            gpo_q    <= i_gpo;
            gpo_qq   <= primed ? gpo_q : i_gpo;
            primed   <= 1'b1;
            state    <= state_n;
            wr_ptr   <= wr_ptr_n;
            full     <= full_n;
            rd_issue <= 1'b0;
            if (exec) begin
                case (cmd)
                    8'h00: o_soft_reset <= ~gpo_q[0];
                    8'h01: begin
                        o_enable_tx <= gpo_q[0];
                        o_enable_rx <= gpo_q[1];
                    end
                    8'h02: rd_ch <= (32'(gpo_q[2:0]) < NB_CH) ? gpo_q[2:0] : 3'd0;
                    8'h03: start_bit <= gpo_q[0];
                    8'h04: begin
                        read_bit <= gpo_q[0];
                        if (gpo_q[0] && !read_bit) begin
                            rd_issue <= 1'b1;
                            rd_addr  <= rd_ptr;
                            rd_ch_q  <= rd_ch;
                            rd_ptr   <= rd_ptr + ADDR_W'(1);
                        end
                    end
                    8'h05: rd_ptr <= '0;
                    default: ;
                endcase
            end
            rd_valid <= rd_issue;
            rd_ch_qq <= rd_ch_q;
            if (rd_valid) gpi_data <= 24'(rd_sel);
        end
    end

    // Per-channel RAM: reads register before any same-edge write lands, giving old data on collision.
    for (genvar k = 0; k < NB_CH; k++) begin : g_ch
        logic [NB_SAMPLE-1:0] mem [RAM_DEPTH];
        logic [NB_SAMPLE-1:0] rd_q;
        always_ff @(posedge clockdsp) begin
            if (wr_en) mem[wr_ptr] <= i_samples[k*NB_SAMPLE +: NB_SAMPLE];
            if (rd_issue) rd_q <= mem[rd_addr];
        end
        assign rd_all[k*NB_SAMPLE +: NB_SAMPLE] = rd_q;
    end

    always_comb begin
        rd_sel = '0;
        for (int unsigned k = 0; k < NB_CH; k++) begin
            if (rd_ch_qq == 3'(k)) rd_sel = rd_all[k*NB_SAMPLE +: NB_SAMPLE];
        end
    end

    assign o_log_full = full;
    assign o_log_busy = (state != ST_IDLE);
    assign o_gpi      = {full, (state != ST_IDLE), 6'b0, gpi_data};

endmodule
